// File: rtl/vita_alu_pkg.sv
// Shared definitions for the decode/execute boundary in front of the 32-bit ALU.
// Holds the ALU control codes, the RV32I opcode/funct constants the decoder needs,
// and the layout of one decoded entry as held in the id_ex_stage skid buffer.
package vita_alu_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned CTRL_W = 4;
  localparam int unsigned REG_W  = 5;

  typedef logic [CTRL_W-1:0] alu_ctrl_t;

  // ALU control codes
  localparam alu_ctrl_t AluAnd     = 4'b0000;
  localparam alu_ctrl_t AluOr      = 4'b0001;
  localparam alu_ctrl_t AluAdd     = 4'b0010;
  localparam alu_ctrl_t AluSub     = 4'b0110;
  localparam alu_ctrl_t AluSlt     = 4'b0111;
  localparam alu_ctrl_t AluXor     = 4'b1000;
  localparam alu_ctrl_t AluSrl     = 4'b1001;
  localparam alu_ctrl_t AluSra     = 4'b1010;
  localparam alu_ctrl_t AluSll     = 4'b1011;
  localparam alu_ctrl_t AluIllegal = 4'b1111;

  // Opcodes
  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcBranch = 7'b1100011;

  // funct3
  localparam logic [2:0] F3AddSub = 3'b000;
  localparam logic [2:0] F3Sll    = 3'b001;
  localparam logic [2:0] F3Slt    = 3'b010;
  localparam logic [2:0] F3Sltu   = 3'b011;
  localparam logic [2:0] F3Xor    = 3'b100;
  localparam logic [2:0] F3Sr     = 3'b101;
  localparam logic [2:0] F3Or     = 3'b110;
  localparam logic [2:0] F3And    = 3'b111;
  localparam logic [2:0] F3Beq    = 3'b000;
  localparam logic [2:0] F3Bne    = 3'b001;

  // funct7
  localparam logic [6:0] F7Base = 7'b0000000;
  localparam logic [6:0] F7Alt  = 7'b0100000;

  typedef struct packed {
    logic [XLEN-1:0]  alu_a;
    logic [XLEN-1:0]  alu_b;
    alu_ctrl_t        alu_control;
    logic [REG_W-1:0] rd;
    logic             reg_write;
    logic             is_branch;
    logic             branch_ne;
    logic             illegal;
  } id_ex_entry_t;

endpackage

// File: rtl/alu_decode.sv
// Combinational RV32I decoder for the ALU subset.
// Ports:
//   instr_i    - instruction word
//   rs1_val_i  - resolved rs1 value (x0 and forwarding already applied)
//   rs2_val_i  - resolved rs2 value (x0 and forwarding already applied)
//   entry_o    - decoded entry: ALU operands in ALU order, control code and flags
module alu_decode
  import vita_alu_pkg::*;
(
  input  logic [XLEN-1:0] instr_i,
  input  logic [XLEN-1:0] rs1_val_i,
  input  logic [XLEN-1:0] rs2_val_i,
  output id_ex_entry_t    entry_o
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] shamt;
  logic            bad;
  logic            f7_alt_ok;
  logic            unused_rs1_idx;

  assign opcode         = instr_i[6:0];
  assign funct3         = instr_i[14:12];
  assign funct7         = instr_i[31:25];
  assign imm_i          = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
  assign shamt          = {{(XLEN-5){1'b0}}, instr_i[24:20]};
  // Only ADD/SUB and SRL/SRA have a second funct7 encoding.
  assign f7_alt_ok      = (funct3 == F3AddSub) || (funct3 == F3Sr);
  // rs1 index is resolved by the parent before the value reaches us.
  assign unused_rs1_idx = ^instr_i[19:15];

  always_comb begin
    entry_o       = '0;
    entry_o.alu_a = rs1_val_i;
    entry_o.alu_b = rs2_val_i;
    entry_o.rd    = instr_i[11:7];
    bad           = 1'b0;

    case (opcode)
      OpcOp: begin
        entry_o.reg_write = 1'b1;
        case (funct3)
          F3AddSub: entry_o.alu_control = (funct7 == F7Alt) ? AluSub : AluAdd;
          F3Sll: begin
            // ALU shifts in_b left by in_a, so the operands are swapped.
            entry_o.alu_control = AluSll;
            entry_o.alu_a       = rs2_val_i;
            entry_o.alu_b       = rs1_val_i;
          end
          F3Slt:   entry_o.alu_control = AluSlt;
          F3Xor:   entry_o.alu_control = AluXor;
          F3Sr:    entry_o.alu_control = (funct7 == F7Alt) ? AluSra : AluSrl;
          F3Or:    entry_o.alu_control = AluOr;
          F3And:   entry_o.alu_control = AluAnd;
          default: bad = 1'b1;
        endcase
        if (!((funct7 == F7Base) || ((funct7 == F7Alt) && f7_alt_ok))) begin
          bad = 1'b1;
        end
      end

      OpcOpImm: begin
        entry_o.reg_write = 1'b1;
        entry_o.alu_b     = imm_i;
        case (funct3)
          F3AddSub: entry_o.alu_control = AluAdd;
          F3Slt:    entry_o.alu_control = AluSlt;
          F3Xor:    entry_o.alu_control = AluXor;
          F3Or:     entry_o.alu_control = AluOr;
          F3And:    entry_o.alu_control = AluAnd;
          F3Sll: begin
            entry_o.alu_control = AluSll;
            entry_o.alu_a       = shamt;
            entry_o.alu_b       = rs1_val_i;
            if (funct7 != F7Base) bad = 1'b1;
          end
          F3Sr: begin
            entry_o.alu_control = (funct7 == F7Alt) ? AluSra : AluSrl;
            entry_o.alu_b       = shamt;
            if ((funct7 != F7Base) && (funct7 != F7Alt)) bad = 1'b1;
          end
          default: bad = 1'b1;
        endcase
      end

      OpcBranch: begin
        entry_o.alu_control = AluSub;
        entry_o.is_branch   = 1'b1;
        case (funct3)
          F3Beq:   entry_o.branch_ne = 1'b0;
          F3Bne:   entry_o.branch_ne = 1'b1;
          default: bad = 1'b1;
        endcase
      end

      default: bad = 1'b1;
    endcase

    if (bad) begin
      entry_o.alu_control = AluIllegal;
      entry_o.illegal     = 1'b1;
      entry_o.reg_write   = 1'b0;
      entry_o.is_branch   = 1'b0;
      entry_o.branch_ne   = 1'b0;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// Decode-to-execute stage in front of the 32-bit ALU: decodes one RV32I instruction
// per handshake and holds decoded entries in a two-entry skid buffer (FIFO).
// Outputs always show the head entry.
// Build option: define ID_EX_FWD_EN to replace rs1/rs2 read data with the writeback
// result at capture time; otherwise the fwd_* inputs are ignored.
// Ports:
//   clk, rst_n (sync, active-low), flush
//   in_valid/in_ready, instr, rs1_data, rs2_data    - upstream
//   fwd_valid, fwd_rd, fwd_data                     - writeback forwarding
//   out_valid/out_ready, alu_a, alu_b, alu_control,
//   rd, reg_write, is_branch, branch_ne, illegal    - head entry to execute
module id_ex_stage
  import vita_alu_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   instr,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  input  logic              fwd_valid,
  input  logic [REG_W-1:0]  fwd_rd,
  input  logic [XLEN-1:0]   fwd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   alu_a,
  output logic [XLEN-1:0]   alu_b,
  output logic [CTRL_W-1:0] alu_control,
  output logic [REG_W-1:0]  rd,
  output logic              reg_write,
  output logic              is_branch,
  output logic              branch_ne,
  output logic              illegal
);

  logic [REG_W-1:0] rs1_idx;
  logic [REG_W-1:0] rs2_idx;
  logic [XLEN-1:0]  rs1_val;
  logic [XLEN-1:0]  rs2_val;
  id_ex_entry_t     new_entry;
  id_ex_entry_t     entry_q [2];
  id_ex_entry_t     entry_d [2];
  logic [1:0]       count_q;
  logic [1:0]       count_d;
  logic             push;
  logic             pop;

  assign rs1_idx = instr[19:15];
  assign rs2_idx = instr[24:20];

`ifdef ID_EX_FWD_EN
  always_comb begin
    rs1_val = rs1_data;
    rs2_val = rs2_data;
    if (fwd_valid && (fwd_rd != '0) && (fwd_rd == rs1_idx)) rs1_val = fwd_data;
    if (fwd_valid && (fwd_rd != '0) && (fwd_rd == rs2_idx)) rs2_val = fwd_data;
    // x0 wins over everything, including forwarding.
    if (rs1_idx == '0) rs1_val = '0;
    if (rs2_idx == '0) rs2_val = '0;
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd_valid, fwd_rd, fwd_data};

  always_comb begin
    rs1_val = (rs1_idx == '0) ? '0 : rs1_data;
    rs2_val = (rs2_idx == '0) ? '0 : rs2_data;
  end
`endif

  alu_decode u_alu_decode (
    .instr_i   (instr),
    .rs1_val_i (rs1_val),
    .rs2_val_i (rs2_val),
    .entry_o   (new_entry)
  );

  // Handshake depends only on registered count (plus rst_n for in_ready).
  assign in_ready  = rst_n & (count_q < 2'(DEPTH));
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Shift-style FIFO: entry 0 is always the head.
  always_comb begin
    entry_d = entry_q;
    count_d = count_q;
    if (flush) begin
      count_d    = '0;
      entry_d[0] = '0;
      entry_d[1] = '0;
    end else begin
      case ({push, pop})
        // Push and pop together only happens at count 1 (count 2 blocks push).
        2'b11: entry_d[0] = new_entry;
        2'b01: begin
          entry_d[0] = entry_q[1];
          entry_d[1] = '0;
          count_d    = count_q - 2'd1;
        end
        2'b10: begin
          if (count_q == 2'd0) entry_d[0] = new_entry;
          else                 entry_d[1] = new_entry;
          count_d = count_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q    <= '0;
      entry_q[0] <= '0;
      entry_q[1] <= '0;
    end else begin
      count_q    <= count_d;
      entry_q[0] <= entry_d[0];
      entry_q[1] <= entry_d[1];
    end
  end

  assign alu_a       = entry_q[0].alu_a;
  assign alu_b       = entry_q[0].alu_b;
  assign alu_control = entry_q[0].alu_control;
  assign rd          = entry_q[0].rd;
  assign reg_write   = entry_q[0].reg_write;
  assign is_branch   = entry_q[0].is_branch;
  assign branch_ne   = entry_q[0].branch_ne;
  assign illegal     = entry_q[0].illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: table of decode vectors pushed through a
// scoreboard queue, plus hand-written reset, back-pressure, flush and latency sequences.
module tb_id_ex_stage;

`ifdef ID_EX_FWD_EN
  localparam bit Fwd = 1'b1;
`else
  localparam bit Fwd = 1'b0;
`endif

  localparam logic [6:0] Op  = 7'h33;
  localparam logic [6:0] Opi = 7'h13;
  localparam logic [6:0] Br  = 7'h63;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic [4:0]  rd;
    logic        rw;
    logic        br;
    logic        bne;
    logic        ill;
  } out_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        fv;
    logic [4:0]  frd;
    logic [31:0] fdata;
    out_t        exp;
    logic        chk_ops;
    logic [15:0] id;
  } vec_t;

  typedef struct packed {
    out_t        exp;
    logic        chk_ops;
    logic [15:0] id;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, fwd_valid, out_valid, out_ready;
  logic [31:0] instr, rs1_data, rs2_data, fwd_data, alu_a, alu_b;
  logic [4:0]  fwd_rd, rd;
  logic [3:0]  alu_control;
  logic        reg_write, is_branch, branch_ne, illegal;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  vec_t vecs[$];
  sb_t  sb_q[$];
  sb_t  cur;
  sb_t  e;
  out_t act, mask;

  id_ex_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .instr       (instr),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .fwd_valid   (fwd_valid),
    .fwd_rd      (fwd_rd),
    .fwd_data    (fwd_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_control (alu_control),
    .rd          (rd),
    .reg_write   (reg_write),
    .is_branch   (is_branch),
    .branch_ne   (branch_ne),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rdf, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rdf, op};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rdf);
    return {imm, rs1, f3, rdf, Opi};
  endfunction

  function automatic out_t mk(input logic [31:0] a, input logic [31:0] b,
                              input logic [3:0] ctrl, input logic [4:0] rdv,
                              input logic rw, input logic br, input logic bne,
                              input logic ill);
    out_t o;
    o.a = a; o.b = b; o.ctrl = ctrl; o.rd = rdv;
    o.rw = rw; o.br = br; o.bne = bne; o.ill = ill;
    return o;
  endfunction

  task automatic add(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2,
                     input logic fv, input logic [4:0] frd, input logic [31:0] fd,
                     input out_t ex, input logic chk);
    vec_t v;
    v.instr = ins; v.rs1 = r1; v.rs2 = r2; v.fv = fv; v.frd = frd; v.fdata = fd;
    v.exp = ex; v.chk_ops = chk; v.id = 16'(vecs.size());
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Scoreboard: compare head on every pop, record expectation on every push.
  always @(negedge clk) begin
    if (!rst_n || flush) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_underflow: got unexpected out_valid, expected empty");
        end else begin
          e    = sb_q.pop_front();
          act  = {alu_a, alu_b, alu_control, rd, reg_write, is_branch, branch_ne, illegal};
          mask = '1;
          if (!e.chk_ops) begin
            mask.a = '0;
            mask.b = '0;
          end
          if ((act & mask) !== (e.exp & mask)) begin
            errors++;
            $display("FAIL sb_entry%0d: got %h, expected %h", e.id, act, e.exp);
          end
        end
      end
      if (in_valid && in_ready) sb_q.push_back(cur);
    end
  end

  task automatic apply(input vec_t v);
    instr = v.instr; rs1_data = v.rs1; rs2_data = v.rs2;
    fwd_valid = v.fv; fwd_rd = v.frd; fwd_data = v.fdata;
    cur.exp = v.exp; cur.chk_ops = v.chk_ops; cur.id = v.id;
    in_valid = 1'b1;
  endtask

  // Called just after a rising edge; returns just after the edge that captured v.
  task automatic send(input vec_t v);
    bit ok = 1'b0;
    apply(v);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout%0d: got in_ready=0 for 20 cycles, expected 1", v.id);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    fwd_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    int c0;
    out_t z;
    z = '0;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instr = '0; rs1_data = '0; rs2_data = '0;
    fwd_valid = 1'b0; fwd_rd = '0; fwd_data = '0;
    cur = '0;

    // Decode table
    add(enc_i(12'hFFB, 2, 3'd0, 1), 10, 32'hAAAA, 0, 0, 0, mk(10, 32'hFFFF_FFFB, 4'h2, 1, 1, 0, 0, 0), 1);
    add(enc_i(12'h007, 4, 3'd1, 3), 1, 32'h55, 0, 0, 0, mk(7, 1, 4'hB, 3, 1, 0, 0, 0), 1);
    add(enc_r(7'h00, 6, 5, 3'd1, 8, Br), 5, 5, 0, 0, 0, mk(5, 5, 4'h6, 8, 0, 1, 1, 0), 1);
    add(enc_r(7'h00, 6, 5, 3'd0, 4, Br), 3, 9, 0, 0, 0, mk(3, 9, 4'h6, 4, 0, 1, 0, 0), 1);
    add(enc_r(7'h00, 2, 1, 3'd0, 7, Op), 100, 23, 0, 0, 0, mk(100, 23, 4'h2, 7, 1, 0, 0, 0), 1);
    add(enc_r(7'h20, 2, 1, 3'd0, 7, Op), 100, 23, 0, 0, 0, mk(100, 23, 4'h6, 7, 1, 0, 0, 0), 1);
    add(enc_r(7'h00, 2, 1, 3'd7, 7, Op), 11, 12, 0, 0, 0, mk(11, 12, 4'h0, 7, 1, 0, 0, 0), 1);
    add(enc_r(7'h00, 2, 1, 3'd6, 7, Op), 11, 12, 0, 0, 0, mk(11, 12, 4'h1, 7, 1, 0, 0, 0), 1);
    add(enc_r(7'h00, 2, 1, 3'd4, 7, Op), 11, 12, 0, 0, 0, mk(11, 12, 4'h8, 7, 1, 0, 0, 0), 1);
    add(enc_r(7'h00, 2, 1, 3'd2, 7, Op), 11, 12, 0, 0, 0, mk(11, 12, 4'h7, 7, 1, 0, 0, 0), 1);
    add(enc_r(7'h00, 2, 1, 3'd5, 7, Op), 11, 12, 0, 0, 0, mk(11, 12, 4'h9, 7, 1, 0, 0, 0), 1);
    add(enc_r(7'h20, 2, 1, 3'd5, 7, Op), 11, 12, 0, 0, 0, mk(11, 12, 4'hA, 7, 1, 0, 0, 0), 1);
    add(enc_r(7'h00, 2, 1, 3'd1, 9, Op), 3, 4, 0, 0, 0, mk(4, 3, 4'hB, 9, 1, 0, 0, 0), 1);
    add(enc_i(12'h403, 2, 3'd5, 1), 32'h8000_0000, 0, 0, 0, 0, mk(32'h8000_0000, 3, 4'hA, 1, 1, 0, 0, 0), 1);
    add(enc_i(12'h01F, 2, 3'd5, 1), 32'h1234, 0, 0, 0, 0, mk(32'h1234, 31, 4'h9, 1, 1, 0, 0, 0), 1);
    add(enc_i(12'h7FF, 2, 3'd6, 1), 32'h10, 0, 0, 0, 0, mk(32'h10, 32'h7FF, 4'h1, 1, 1, 0, 0, 0), 1);
    add(enc_i(12'h800, 2, 3'd7, 1), 32'h10, 0, 0, 0, 0, mk(32'h10, 32'hFFFF_F800, 4'h0, 1, 1, 0, 0, 0), 1);
    add(enc_i(12'h123, 2, 3'd4, 1), 32'h10, 0, 0, 0, 0, mk(32'h10, 32'h123, 4'h8, 1, 1, 0, 0, 0), 1);
    add(enc_i(12'hFFF, 2, 3'd2, 1), 32'h10, 0, 0, 0, 0, mk(32'h10, 32'hFFFF_FFFF, 4'h7, 1, 1, 0, 0, 0), 1);
    // Illegal encodings: SLTU, SLTIU, BLT, LOAD, bad funct7 on ADD/SLLI/SRL
    add(enc_r(7'h00, 2, 1, 3'd3, 10, Op), 1, 2, 0, 0, 0, mk(0, 0, 4'hF, 10, 0, 0, 0, 1), 0);
    add(enc_i(12'h005, 2, 3'd3, 10), 1, 2, 0, 0, 0, mk(0, 0, 4'hF, 10, 0, 0, 0, 1), 0);
    add(enc_r(7'h00, 2, 1, 3'd4, 10, Br), 1, 2, 0, 0, 0, mk(0, 0, 4'hF, 10, 0, 0, 0, 1), 0);
    add(enc_r(7'h00, 2, 1, 3'd2, 10, 7'h03), 1, 2, 0, 0, 0, mk(0, 0, 4'hF, 10, 0, 0, 0, 1), 0);
    add(enc_r(7'h01, 2, 1, 3'd0, 10, Op), 1, 2, 0, 0, 0, mk(0, 0, 4'hF, 10, 0, 0, 0, 1), 0);
    add(enc_i(12'h405, 2, 3'd1, 10), 1, 2, 0, 0, 0, mk(0, 0, 4'hF, 10, 0, 0, 0, 1), 0);
    add(enc_r(7'h01, 2, 1, 3'd5, 10, Op), 1, 2, 0, 0, 0, mk(0, 0, 4'hF, 10, 0, 0, 0, 1), 0);
    // x0 sources
    add(enc_r(7'h00, 3, 0, 3'd0, 1, Op), 32'hDEAD, 5, 0, 0, 0, mk(0, 5, 4'h2, 1, 1, 0, 0, 0), 1);
    add(enc_r(7'h00, 0, 3, 3'd0, 1, Op), 7, 32'hBEEF, 0, 0, 0, mk(7, 0, 4'h2, 1, 1, 0, 0, 0), 1);
    // Forwarding
    add(enc_r(7'h00, 0, 2, 3'd0, 1, Op), 32'h99, 32'h77, 1, 2, 32'h55,
        mk(Fwd ? 32'h55 : 32'h99, 0, 4'h2, 1, 1, 0, 0, 0), 1);
    add(enc_r(7'h00, 3, 2, 3'd0, 1, Op), 1, 2, 1, 3, 32'h66,
        mk(1, Fwd ? 32'h66 : 2, 4'h2, 1, 1, 0, 0, 0), 1);
    add(enc_r(7'h00, 3, 2, 3'd0, 1, Op), 1, 2, 0, 2, 32'h66, mk(1, 2, 4'h2, 1, 1, 0, 0, 0), 1);
    add(enc_r(7'h00, 3, 0, 3'd0, 1, Op), 32'h44, 2, 1, 0, 32'h77, mk(0, 2, 4'h2, 1, 1, 0, 0, 0), 1);
    add(enc_r(7'h00, 2, 2, 3'd0, 1, Op), 8, 8, 1, 2, 32'h31,
        mk(Fwd ? 32'h31 : 8, Fwd ? 32'h31 : 8, 4'h2, 1, 1, 0, 0, 0), 1);
    add(enc_i(12'h004, 6, 3'd1, 5), 32'h3, 0, 1, 6, 32'h100,
        mk(4, Fwd ? 32'h100 : 3, 4'hB, 5, 1, 0, 0, 0), 1);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_outputs", 32'(|{alu_a, alu_b, alu_control, rd, reg_write, is_branch,
                             branch_ne, illegal}), 0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_in_ready", 32'(in_ready), 1);
    check("rel_out_valid", 32'(out_valid), 0);
    step();

    // Latency: captured at edge N, visible after edge N
    out_ready = 1'b1;
    send(vecs[0]);
    @(negedge clk);
    check("lat_out_valid", 32'(out_valid), 1);
    step();
    @(negedge clk);
    check("lat_drained", 32'(out_valid), 0);
    step();

    // Table at full throughput
    c0 = cyc;
    foreach (vecs[i]) send(vecs[i]);
    check("throughput_cycles", 32'(cyc - c0), 32'(vecs.size()));
    repeat (3) step();
    check("table_sb_empty", 32'(sb_q.size()), 0);

    // Back-pressure: A, B accepted, C held off until drain
    out_ready = 1'b0;
    apply(vecs[4]);
    @(negedge clk); check("bp_rdy0", 32'(in_ready), 1);
    step(); apply(vecs[5]);
    @(negedge clk); check("bp_rdy1", 32'(in_ready), 1);
    step(); apply(vecs[6]);
    @(negedge clk); check("bp_rdy2", 32'(in_ready), 0);
    check("bp_valid2", 32'(out_valid), 1);
    step();
    @(negedge clk); check("bp_rdy3", 32'(in_ready), 0);
    step(); out_ready = 1'b1;
    @(negedge clk); check("bp_rdy4", 32'(in_ready), 0);
    step();
    @(negedge clk); check("bp_rdy5", 32'(in_ready), 1);
    step(); in_valid = 1'b0;
    repeat (2) step();
    check("bp_sb_empty", 32'(sb_q.size()), 0);
    check("bp_out_valid", 32'(out_valid), 0);

    // Flush at count 2 with in_valid
    out_ready = 1'b0;
    apply(vecs[1]); step();
    apply(vecs[2]); step();
    apply(vecs[3]); flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("fl2_out_valid", 32'(out_valid), 0);
    check("fl2_in_ready", 32'(in_ready), 1);
    step();

    // Flush at count 1 with a push in the flush cycle
    apply(vecs[7]); step();
    apply(vecs[8]); flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("fl1_out_valid", 32'(out_valid), 0);
    step();
    out_ready = 1'b1;
    send(vecs[9]);
    repeat (2) step();
    check("fl_sb_empty", 32'(sb_q.size()), 0);

    // Reset mid-operation discards buffered entries
    out_ready = 1'b0;
    apply(vecs[10]); step();
    apply(vecs[11]); step();
    in_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    check("mrst_in_ready", 32'(in_ready), 0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("mrst_out_valid", 32'(out_valid), 0);
    check("mrst_alu_a", alu_a, 0);
    check("mrst_alu_ctrl", 32'(alu_control), 0);
    check("mrst_in_ready", 32'(in_ready), 1);
    step();
    out_ready = 1'b1;
    send(vecs[12]);
    repeat (2) step();
    check("final_sb_empty", 32'(sb_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
